// File: rtl/data_ram.sv
// data_ram: byte-addressed data memory with a valid/ready request port and
// optional wait states. Define DATA_RAM_SIGNEXT_EN for signed narrow reads.
module data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_exception
);

`ifdef DATA_RAM_SIGNEXT_EN
  localparam logic SIGNEXT = 1'b1;
`else
  localparam logic SIGNEXT = 1'b0;
`endif

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  logic [3:0] cnt;

  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [7:0] mem [2**ADDR_WIDTH];

  logic                  req_mis;
  logic                  a_we;
  logic [1:0]            a_size;
  logic                  a_uns;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_wdata;
  logic [ADDR_WIDTH-1:0] i0, i1, i2, i3;
  logic                  access;
  logic                  sx;
  logic [31:0]           rd_raw;
  logic [31:0]           rd_ext;

  assign req_ready = (state == S_IDLE);

  // misalignment decode of the incoming request
  always_comb begin
    req_mis = 1'b0;
    unique case (1'b1)
      req_size == 2'b01: req_mis = req_addr[0];
      req_size == 2'b10: req_mis = |req_addr[1:0];
      req_size == 2'b11: req_mis = 1'b1;
      default:           req_mis = 1'b0;
    endcase
  end

  // access fields: live inputs on the accept edge, latched copy afterwards
  always_comb begin
    a_we    = req_we;
    a_size  = req_size;
    a_uns   = req_unsigned;
    a_addr  = req_addr;
    a_wdata = req_wdata;
    if (state != S_IDLE) begin
      a_we    = we_q;
      a_size  = size_q;
      a_uns   = uns_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
    i0 = a_addr;
    i1 = a_addr + ADDR_WIDTH'(1);
    i2 = a_addr + ADDR_WIDTH'(2);
    i3 = a_addr + ADDR_WIDTH'(3);
    access = (state == S_IDLE && req_valid && !req_mis && WS == 4'd0)
          || (state == S_WAIT && cnt == 4'd1);
  end

  // little-endian read assembly and narrow-read extension
  always_comb begin
    rd_raw = {mem[i3], mem[i2], mem[i1], mem[i0]};
    sx     = SIGNEXT && !a_uns;
    rd_ext = rd_raw;
    unique case (a_size)
      2'b00:   rd_ext = {{24{sx && rd_raw[7]}}, rd_raw[7:0]};
      2'b01:   rd_ext = {{16{sx && rd_raw[15]}}, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase
  end

  // byte-enabled write, committed only on the edge entering RESP
  always_ff @(posedge clk) begin
    if (access && a_we && !rst) begin
      mem[i0] <= a_wdata[7:0];
      if (a_size != 2'b00) begin
        mem[i1] <= a_wdata[15:8];
      end
      if (a_size == 2'b10) begin
        mem[i2] <= a_wdata[23:16];
        mem[i3] <= a_wdata[31:24];
      end
    end
  end

  // control FSM with registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 32'd0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_exception <= 1'b0;
    end else begin
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_exception <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_mis) begin
              state         <= S_RESP;
              rsp_valid     <= 1'b1;
              rsp_exception <= 1'b1;
            end else if (WS == 4'd0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= req_we ? 32'd0 : rd_ext;
            end else begin
              state <= S_WAIT;
              cnt   <= WS;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state     <= S_RESP;
            cnt       <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? 32'd0 : rd_ext;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, byte-address width; the array holds 2**ADDR_WIDTH bytes.
REQ-002 Parameter WAIT_STATES, default 0, extra cycles inserted between request acceptance and the array access (0..15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned  in  1  zero-extend narrow reads (see REQ-026).
REQ-010 req_addr  in  ADDR_WIDTH  byte address.
REQ-011 req_wdata  in  32  write data, right-aligned.
REQ-012 rsp_valid  out  1  one-cycle response pulse.
REQ-013 rsp_rdata  out  32  read data, right-aligned.
REQ-014 rsp_exception  out  1  request rejected, valid with rsp_valid.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Handshake: request accepted on a rising edge with req_valid=1 and req_ready=1; all req_* fields SHALL be latched at acceptance and ignored afterwards.
REQ-017 Misaligned SHALL mean size 01 with addr[0]=1, size 10 with addr[1:0]!=00, or size 11.
REQ-018 Misaligned request: IDLE->RESP directly, no array access, rsp_exception=1, rsp_rdata=0.
REQ-019 Aligned request: IDLE->WAIT if WAIT_STATES>0, else IDLE->RESP; WAIT SHALL hold exactly WAIT_STATES cycles (down-counter), then ->RESP.
REQ-020 The array access SHALL occur on the edge entering RESP; writes commit only then.
REQ-021 Byte order little-endian: wdata[7:0] to addr, wdata[15:8] to addr+1, etc.; reads assemble identically.
REQ-022 Writes SHALL modify only the bytes selected by size; other bytes are unchanged.
REQ-023 In RESP: rsp_valid=1 for exactly one cycle, then ->IDLE; accepted-to-rsp_valid latency SHALL be 1+WAIT_STATES cycles.
REQ-024 Writes SHALL return rsp_rdata=0, rsp_exception=0.
REQ-025 rsp_rdata and rsp_exception SHALL be 0 whenever rsp_valid=0.
REQ-026 Narrow reads SHALL be extended to 32 bits per REQ-040/REQ-041.
REQ-027 Back-to-back: a new request can be accepted the cycle after RESP; a read following a write to the same address SHALL return the new data.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_exception=0, wait counter=0.
REQ-029 Reset during WAIT SHALL discard the pending request; a pending write SHALL NOT commit.
REQ-030 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-040 With DATA_RAM_SIGNEXT_EN defined: byte/halfword reads sign-extend from bit 7/15 when req_unsigned=0, zero-extend when req_unsigned=1.
REQ-041 Without DATA_RAM_SIGNEXT_EN: narrow reads always zero-extend; req_unsigned is ignored.

Verification
REQ-050 WAIT_STATES=0: word write 0x11223344 @0x008, word read @0x008 -> rsp_valid 1 cycle after acceptance, rdata=0x11223344; byte read @0x009 -> 0x00000033.
REQ-051 Halfword write 0xBEEF @0x010 over word 0x00000000 -> word read @0x010 = 0x0000BEEF; halfword read req_unsigned=0 -> 0xFFFFBEEF with macro, 0x0000BEEF without.
REQ-052 Word read @0x002, halfword @0x003, size 11 @0x000 -> rsp_exception=1, rdata=0, array unchanged.
REQ-053 WAIT_STATES=3: read accepted -> req_ready=0 for 4 cycles, rsp_valid on 4th cycle after acceptance; req_valid held high -> next acceptance the cycle after rsp_valid.
REQ-054 WAIT_STATES=3: write 0xCAFEF00D @0x020, rst asserted during WAIT -> outputs zero at once, req_ready=1; later read @0x020 returns prior contents.
